// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register feeding a small {pc, inst} FIFO toward decode.
// Redirects flush the buffer and reload the PC; the buffer head drives the decode outputs.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        iClk,
  input  logic        iRst_n,
  output logic [31:0] oRomAddr,
  input  logic [31:0] iRomData,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  output logic        oInstValid,
  input  logic        iInstReady,
  output logic [31:0] oInst,
  output logic [31:0] oInstPc
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0]      NOP_INST = 32'h0000_0013;

  logic [31:0]      pc_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [31:0]      fifo_pc_r   [DEPTH];
  logic [31:0]      fifo_inst_r [DEPTH];
  logic             pop_s;
  logic             push_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == LAST_PTR) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + PTR_W'(1'b1);
    end
    return n;
  endfunction

  assign oRomAddr = pc_r;
  assign pop_s    = oInstValid & iInstReady;
  assign push_s   = ~iRedirect & ((count_r < FULL_CNT) | pop_s);

  // Head-of-buffer view; an empty buffer presents a NOP at address zero.
  always_comb begin
    oInstValid = 1'b0;
    oInst      = NOP_INST;
    oInstPc    = 32'h0000_0000;
    if (count_r != {CNT_W{1'b0}}) begin
      oInstValid = 1'b1;
      oInst      = fifo_inst_r[head_r];
      oInstPc    = fifo_pc_r[head_r];
    end else begin
      oInstValid = 1'b0;
      oInst      = NOP_INST;
      oInstPc    = 32'h0000_0000;
    end
  end

  // PC, pointers and occupancy; a redirect overrides any push or pop in its cycle.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pc_r    <= RESET_PC;
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (iRedirect) begin
      // Low address bits are masked so the target is always word-aligned.
      pc_r    <= iRedirectPc & 32'hFFFF_FFFC;
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        pc_r   <= pc_r + 32'd4;
        tail_r <= ptr_inc(tail_r);
      end else begin
        pc_r   <= pc_r;
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end else begin
        head_r <= head_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Buffer storage, written at the tail on every push.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_r[i]   <= 32'h0000_0000;
        fifo_inst_r[i] <= NOP_INST;
      end
    end else if (push_s) begin
      fifo_pc_r[tail_r]   <= pc_r;
      fifo_inst_r[tail_r] <= iRomData;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_r[i]   <= fifo_pc_r[i];
        fifo_inst_r[i] <= fifo_inst_r[i];
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stall/release, redirects, full-FIFO redirect,
// PC wraparound and asynchronous reset, checked against hand-derived addresses.
module tb_inst_fetch;

  logic        iClk;
  logic        iRst_n;
  logic [31:0] oRomAddr;
  logic [31:0] iRomData;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic        oInstValid;
  logic        iInstReady;
  logic [31:0] oInst;
  logic [31:0] oInstPc;

  int checks;
  int errors;

  localparam logic [31:0] NOP = 32'h0000_0013;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .oRomAddr    (oRomAddr),
    .iRomData    (iRomData),
    .iRedirect   (iRedirect),
    .iRedirectPc (iRedirectPc),
    .oInstValid  (oInstValid),
    .iInstReady  (iInstReady),
    .oInst       (oInst),
    .oInstPc     (oInstPc)
  );

  // ROM content: a distinct word per address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {~a[17:2], a[17:2]} ^ 32'h5A00_00A5;
  endfunction

  assign iRomData = rom(oRomAddr);

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, oInstValid}, 32'd1);
    check({tag, ".pc"}, oInstPc, pc);
    check({tag, ".inst"}, oInst, rom(pc));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    iRst_n      = 1'b0;
    iRedirect   = 1'b0;
    iRedirectPc = 32'h0000_0000;
    iInstReady  = 1'b0;
    #1;
    check("rst.valid", {31'd0, oInstValid}, 32'd0);
    check("rst.inst", oInst, NOP);
    check("rst.pc", oInstPc, 32'h0);
    check("rst.romaddr", oRomAddr, 32'h0);
    tick();
    tick();
    iRst_n = 1'b1;

    // Stall with decode not ready: two entries buffered, PC stops at 8.
    tick();
    head("stall0", 32'h0);
    check("stall0.romaddr", oRomAddr, 32'h4);
    tick();
    head("stall1", 32'h0);
    check("stall1.romaddr", oRomAddr, 32'h8);
    tick();
    head("stall2", 32'h0);
    check("stall2.romaddr", oRomAddr, 32'h8);
    iInstReady = 1'b1;
    tick();
    head("rel4", 32'h4);
    check("rel4.romaddr", oRomAddr, 32'hC);
    tick();
    head("rel8", 32'h8);
    tick();
    head("rel12", 32'hC);
    check("rel12.romaddr", oRomAddr, 32'h14);

    // Redirect while streaming; low target bits are ignored.
    iRedirect   = 1'b1;
    iRedirectPc = 32'h0000_0042;
    tick();
    iRedirect = 1'b0;
    check("redir.valid", {31'd0, oInstValid}, 32'd0);
    check("redir.romaddr", oRomAddr, 32'h40);
    check("redir.inst", oInst, NOP);
    check("redir.pc", oInstPc, 32'h0);
    tick();
    head("redir.tgt", 32'h40);
    check("redir.tgt.romaddr", oRomAddr, 32'h44);

    // Fill the FIFO, then pop and redirect together.
    iInstReady = 1'b0;
    tick();
    check("full.romaddr", oRomAddr, 32'h48);
    tick();
    head("full.head", 32'h40);
    check("full.hold", oRomAddr, 32'h48);
    iInstReady  = 1'b1;
    iRedirect   = 1'b1;
    iRedirectPc = 32'h0000_0100;
    tick();
    iRedirect  = 1'b0;
    iInstReady = 1'b0;
    check("fullredir.valid", {31'd0, oInstValid}, 32'd0);
    check("fullredir.romaddr", oRomAddr, 32'h100);
    tick();
    head("fullredir.tgt", 32'h100);
    iInstReady = 1'b1;
    tick();
    head("fullredir.next", 32'h104);
    check("fullredir.romaddr2", oRomAddr, 32'h108);

    // PC wraparound.
    iRedirect   = 1'b1;
    iRedirectPc = 32'hFFFF_FFFE;
    tick();
    iRedirect = 1'b0;
    check("wrap.valid", {31'd0, oInstValid}, 32'd0);
    check("wrap.romaddr", oRomAddr, 32'hFFFF_FFFC);
    tick();
    head("wrap.top", 32'hFFFF_FFFC);
    check("wrap.romaddr2", oRomAddr, 32'h0);
    tick();
    head("wrap.zero", 32'h0);
    check("wrap.romaddr3", oRomAddr, 32'h4);

    // Fill, then assert reset asynchronously between edges.
    iInstReady = 1'b0;
    tick();
    check("pre.romaddr", oRomAddr, 32'h8);
    tick();
    head("pre.head", 32'h0);
    #2;
    iRst_n = 1'b0;
    #1;
    check("async.valid", {31'd0, oInstValid}, 32'd0);
    check("async.inst", oInst, NOP);
    check("async.pc", oInstPc, 32'h0);
    check("async.romaddr", oRomAddr, 32'h0);
    tick();
    check("async.hold", {31'd0, oInstValid}, 32'd0);
    iRst_n     = 1'b1;
    iInstReady = 1'b1;

    // Continuous streaming from reset.
    tick();
    head("s0", 32'h0);
    check("s0.romaddr", oRomAddr, 32'h4);
    tick();
    head("s4", 32'h4);
    tick();
    head("s8", 32'h8);
    tick();
    head("s12", 32'hC);
    check("s12.romaddr", oRomAddr, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
